// File: rtl/rv32i_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv32i_pkg
// Description : Shared opcode constants, ALU operation codes, immediate
//               formats and the decode bundle for the RV32I/RV32E core.
// Revision    : 1.0 - initial release
// ============================================================================
package rv32i_pkg;

   localparam int DEFAULT_XLEN = 32;

   // Major opcodes (instr[6:0])
   localparam logic [6:0] OPC_LUI      = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
   localparam logic [6:0] OPC_JAL      = 7'b1101111;
   localparam logic [6:0] OPC_JALR     = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
   localparam logic [6:0] OPC_LOAD     = 7'b0000011;
   localparam logic [6:0] OPC_STORE    = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
   localparam logic [6:0] OPC_OP       = 7'b0110011;
   localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

   // Encoded as {funct7[5], funct3} so OP/OP-IMM can pass fields straight through
   typedef enum logic [3:0] {
      ALU_ADD  = 4'b0000,
      ALU_SLL  = 4'b0001,
      ALU_SLT  = 4'b0010,
      ALU_SLTU = 4'b0011,
      ALU_XOR  = 4'b0100,
      ALU_SRL  = 4'b0101,
      ALU_OR   = 4'b0110,
      ALU_AND  = 4'b0111,
      ALU_SUB  = 4'b1000,
      ALU_SRA  = 4'b1101
   } alu_op_e;

   typedef enum logic [2:0] {
      FMT_I = 3'd0,
      FMT_S = 3'd1,
      FMT_B = 3'd2,
      FMT_U = 3'd3,
      FMT_J = 3'd4,
      FMT_R = 3'd5
   } imm_fmt_e;

   // Everything the decoder derives from one instruction word
   typedef struct packed {
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic [4:0] rd;
      imm_fmt_e   fmt;
      logic [3:0] alu_op;
      logic       alu_src_imm;
      logic       reg_write;
      logic       mem_read;
      logic       mem_write;
      logic       branch;
      logic       jump;
      logic       illegal;
   } decode_t;

   // True when a register index exists in a file of num registers
   function automatic logic in_range(input logic [4:0] idx, input int num);
      return int'(idx) < num;
   endfunction

endpackage
`default_nettype wire

// File: rtl/rv32i_regfile_2r1w.sv
`default_nettype none
// ============================================================================
// Module      : rv32i_regfile_2r1w
// Description : Architectural register file, two combinational read ports,
//               one synchronous write port, x0 hardwired to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module rv32i_regfile_2r1w
   import rv32i_pkg::*;
#(
   parameter int XLEN     = DEFAULT_XLEN,
   parameter int NUM_REGS = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [4:0]      raddr1,
   output logic [XLEN-1:0] rdata1,
   input  logic [4:0]      raddr2,
   output logic [XLEN-1:0] rdata2,
   input  logic            we,
   input  logic [4:0]      waddr,
   input  logic [XLEN-1:0] wdata
);

   localparam int AW = $clog2(NUM_REGS);

   logic [XLEN-1:0] regs [NUM_REGS];

   // Write port: x0 and indices beyond the file are silently dropped
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      end else if (we && (waddr != 5'd0) && in_range(waddr, NUM_REGS)) begin
         regs[waddr[AW-1:0]] <= wdata;
      end
   end

   // Read ports: x0 and out-of-range indices return zero
   always_comb begin
      rdata1 = '0;
      rdata2 = '0;
      if ((raddr1 != 5'd0) && in_range(raddr1, NUM_REGS)) rdata1 = regs[raddr1[AW-1:0]];
      if ((raddr2 != 5'd0) && in_range(raddr2, NUM_REGS)) rdata2 = regs[raddr2[AW-1:0]];
   end

endmodule
`default_nettype wire

// File: rtl/rv32i_decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : rv32i_decode_stage
// Description : Valid/ready instruction-decode stage: register file read,
//               full RV32I decode, immediate generation, writeback forwarding
//               (at capture and while stalled) and flush.
// Revision    : 1.0 - initial release
// ============================================================================
module rv32i_decode_stage
   import rv32i_pkg::*;
#(
   parameter int XLEN     = DEFAULT_XLEN,
   parameter int NUM_REGS = 32,
   parameter int BYPASS   = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            if_valid,
   output logic            if_ready,
   input  logic [31:0]     if_instr,
   input  logic [XLEN-1:0] if_pc,
   input  logic            wb_en,
   input  logic [4:0]      wb_rd,
   input  logic [XLEN-1:0] wb_data,
   output logic            id_valid,
   input  logic            id_ready,
   output logic [XLEN-1:0] id_pc,
   output logic [4:0]      id_rs1,
   output logic [4:0]      id_rs2,
   output logic [4:0]      id_rd,
   output logic [XLEN-1:0] id_rs1_data,
   output logic [XLEN-1:0] id_rs2_data,
   output logic [XLEN-1:0] id_imm,
   output logic [3:0]      id_alu_op,
   output logic            id_alu_src_imm,
   output logic            id_reg_write,
   output logic            id_mem_read,
   output logic            id_mem_write,
   output logic            id_branch,
   output logic            id_jump,
   output logic            id_illegal
);

   // Full decode of one instruction word; illegal forms keep their fields but lose all enables
   function automatic decode_t decode(input logic [31:0] instr);
      decode_t    d;
      logic [6:0] opc;
      logic [2:0] f3;
      logic [6:0] f7;
      logic       use_rs1, use_rs2, use_rd;
      d       = '0;
      d.fmt   = FMT_R;
      d.alu_op = ALU_ADD;
      opc     = instr[6:0];
      f3      = instr[14:12];
      f7      = instr[31:25];
      use_rs1 = 1'b0;
      use_rs2 = 1'b0;
      use_rd  = 1'b0;
      case (opc)
         OPC_LUI, OPC_AUIPC: begin
            d.fmt = FMT_U; use_rd = 1'b1; d.alu_src_imm = 1'b1; d.reg_write = 1'b1;
         end
         OPC_JAL: begin
            d.fmt = FMT_J; use_rd = 1'b1; d.alu_src_imm = 1'b1; d.reg_write = 1'b1; d.jump = 1'b1;
         end
         OPC_JALR: begin
            d.fmt = FMT_I; use_rd = 1'b1; use_rs1 = 1'b1;
            d.alu_src_imm = 1'b1; d.reg_write = 1'b1; d.jump = 1'b1;
         end
         OPC_BRANCH: begin
            d.fmt = FMT_B; use_rs1 = 1'b1; use_rs2 = 1'b1; d.branch = 1'b1;
            d.alu_op = {1'b0, f3};
         end
         OPC_LOAD: begin
            d.fmt = FMT_I; use_rd = 1'b1; use_rs1 = 1'b1;
            d.alu_src_imm = 1'b1; d.reg_write = 1'b1; d.mem_read = 1'b1;
         end
         OPC_STORE: begin
            d.fmt = FMT_S; use_rs1 = 1'b1; use_rs2 = 1'b1;
            d.alu_src_imm = 1'b1; d.mem_write = 1'b1;
         end
         OPC_OP_IMM: begin
            d.fmt = FMT_I; use_rd = 1'b1; use_rs1 = 1'b1;
            d.alu_src_imm = 1'b1; d.reg_write = 1'b1;
            d.alu_op = {f7[5] & (f3 == 3'b101), f3};
         end
         OPC_OP: begin
            d.fmt = FMT_R; use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; d.reg_write = 1'b1;
            d.alu_op = {f7[5], f3};
            // funct7=0x20 is only meaningful on the ADD/SUB and SRL/SRA slots
            if (!((f7 == 7'h00) || ((f7 == 7'h20) && ((f3 == 3'b000) || (f3 == 3'b101)))))
               d.illegal = 1'b1;
         end
         OPC_MISC_MEM: begin
            // FENCE is a no-op in this in-order pipeline
            d.fmt = FMT_R;
         end
         OPC_SYSTEM: begin
            d.fmt = FMT_I;
            // Only ECALL (imm=0) and EBREAK (imm=1) with all other fields zero
            if (!((instr[31:7] == 25'h0) || (instr[31:7] == 25'h0002000)))
               d.illegal = 1'b1;
         end
         default: d.illegal = 1'b1;
      endcase
      if (instr[1:0] != 2'b11) d.illegal = 1'b1;
      d.rs1 = use_rs1 ? instr[19:15] : 5'd0;
      d.rs2 = use_rs2 ? instr[24:20] : 5'd0;
      d.rd  = use_rd  ? instr[11:7]  : 5'd0;
      if (!in_range(d.rs1, NUM_REGS) || !in_range(d.rs2, NUM_REGS) || !in_range(d.rd, NUM_REGS))
         d.illegal = 1'b1;
      if (d.rd == 5'd0) d.reg_write = 1'b0;
      if (d.illegal) begin
         d.alu_src_imm = 1'b0;
         d.reg_write   = 1'b0;
         d.mem_read    = 1'b0;
         d.mem_write   = 1'b0;
         d.branch      = 1'b0;
         d.jump        = 1'b0;
      end
      return d;
   endfunction

   // Sign-extended immediate for the given instruction format
   function automatic logic [XLEN-1:0] imm_gen(input logic [31:0] instr, input imm_fmt_e fmt);
      logic [XLEN-1:0] imm;
      case (fmt)
         FMT_I:   imm = {{(XLEN-12){instr[31]}}, instr[31:20]};
         FMT_S:   imm = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
         FMT_B:   imm = {{(XLEN-12){instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
         FMT_U:   imm = {instr[31:12], 12'b0};
         FMT_J:   imm = {{(XLEN-20){instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
         default: imm = '0;
      endcase
      return imm;
   endfunction

   // A writeback that really lands in register idx this cycle
   function automatic logic wb_hits(input logic [4:0] idx);
      return wb_en && (idx != 5'd0) && (idx == wb_rd) && in_range(wb_rd, NUM_REGS);
   endfunction

   decode_t         dec;
   logic [XLEN-1:0] dec_imm;
   logic [XLEN-1:0] rf_rdata1, rf_rdata2;
   logic [XLEN-1:0] op1, op2;
   logic            hold_upd1, hold_upd2;
   logic            accept;

   // Combinational decode of the instruction offered by fetch
   always_comb begin
      dec     = decode(if_instr);
      dec_imm = imm_gen(if_instr, dec.fmt);
   end

   rv32i_regfile_2r1w #(
      .XLEN     (XLEN),
      .NUM_REGS (NUM_REGS)
   ) u_regfile (
      .clk    (clk),
      .rst    (rst),
      .raddr1 (dec.rs1),
      .rdata1 (rf_rdata1),
      .raddr2 (dec.rs2),
      .rdata2 (rf_rdata2),
      .we     (wb_en),
      .waddr  (wb_rd),
      .wdata  (wb_data)
   );

   generate
      if (BYPASS != 0) begin : g_bypass
         // Forward writeback into operands being captured and into a stalled instruction
         always_comb begin
            op1       = wb_hits(dec.rs1) ? wb_data : rf_rdata1;
            op2       = wb_hits(dec.rs2) ? wb_data : rf_rdata2;
            hold_upd1 = id_valid && !id_ready && wb_hits(id_rs1);
            hold_upd2 = id_valid && !id_ready && wb_hits(id_rs2);
         end
      end else begin : g_no_bypass
         // Plain register-file read, held operands frozen
         always_comb begin
            op1       = rf_rdata1;
            op2       = rf_rdata2;
            hold_upd1 = 1'b0;
            hold_upd2 = 1'b0;
         end
      end
   endgenerate

   assign if_ready = !id_valid || id_ready;
   assign accept   = if_valid && if_ready;

   // Pipeline register: flush beats capture, capture beats drain, stall keeps contents
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         id_valid       <= 1'b0;
         id_pc          <= '0;
         id_rs1         <= '0;
         id_rs2         <= '0;
         id_rd          <= '0;
         id_rs1_data    <= '0;
         id_rs2_data    <= '0;
         id_imm         <= '0;
         id_alu_op      <= '0;
         id_alu_src_imm <= 1'b0;
         id_reg_write   <= 1'b0;
         id_mem_read    <= 1'b0;
         id_mem_write   <= 1'b0;
         id_branch      <= 1'b0;
         id_jump        <= 1'b0;
         id_illegal     <= 1'b0;
      end else if (flush) begin
         id_valid <= 1'b0;
      end else if (accept) begin
         id_valid       <= 1'b1;
         id_pc          <= if_pc;
         id_rs1         <= dec.rs1;
         id_rs2         <= dec.rs2;
         id_rd          <= dec.rd;
         id_rs1_data    <= op1;
         id_rs2_data    <= op2;
         id_imm         <= dec_imm;
         id_alu_op      <= dec.alu_op;
         id_alu_src_imm <= dec.alu_src_imm;
         id_reg_write   <= dec.reg_write;
         id_mem_read    <= dec.mem_read;
         id_mem_write   <= dec.mem_write;
         id_branch      <= dec.branch;
         id_jump        <= dec.jump;
         id_illegal     <= dec.illegal;
      end else if (id_ready) begin
         id_valid <= 1'b0;
      end else begin
         if (hold_upd1) id_rs1_data <= wb_data;
         if (hold_upd2) id_rs2_data <= wb_data;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_rv32i_decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_rv32i_decode_stage
// Description : Directed self-checking bench; one instance with default
//               parameters and one with BYPASS=0, NUM_REGS=16 on shared inputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rv32i_decode_stage;

   logic        clk = 1'b0;
   logic        rst, flush, if_valid, wb_en, id_ready;
   logic [31:0] if_instr, if_pc, wb_data;
   logic [4:0]  wb_rd;

   logic        if_ready, id_valid, id_alu_src_imm, id_reg_write, id_mem_read, id_mem_write;
   logic        id_branch, id_jump, id_illegal;
   logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
   logic [4:0]  id_rs1, id_rs2, id_rd;
   logic [3:0]  id_alu_op;

   logic        a_if_ready, a_id_valid, a_id_alu_src_imm, a_id_reg_write, a_id_mem_read, a_id_mem_write;
   logic        a_id_branch, a_id_jump, a_id_illegal;
   logic [31:0] a_id_pc, a_id_rs1_data, a_id_rs2_data, a_id_imm;
   logic [4:0]  a_id_rs1, a_id_rs2, a_id_rd;
   logic [3:0]  a_id_alu_op;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   rv32i_decode_stage #(.XLEN(32), .NUM_REGS(32), .BYPASS(1)) dut (
      .clk(clk), .rst(rst), .flush(flush), .if_valid(if_valid), .if_ready(if_ready),
      .if_instr(if_instr), .if_pc(if_pc), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
      .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_rd(id_rd), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
      .id_alu_op(id_alu_op), .id_alu_src_imm(id_alu_src_imm), .id_reg_write(id_reg_write),
      .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_branch(id_branch),
      .id_jump(id_jump), .id_illegal(id_illegal)
   );

   rv32i_decode_stage #(.XLEN(32), .NUM_REGS(16), .BYPASS(0)) dut_alt (
      .clk(clk), .rst(rst), .flush(flush), .if_valid(if_valid), .if_ready(a_if_ready),
      .if_instr(if_instr), .if_pc(if_pc), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
      .id_valid(a_id_valid), .id_ready(id_ready), .id_pc(a_id_pc), .id_rs1(a_id_rs1), .id_rs2(a_id_rs2),
      .id_rd(a_id_rd), .id_rs1_data(a_id_rs1_data), .id_rs2_data(a_id_rs2_data), .id_imm(a_id_imm),
      .id_alu_op(a_id_alu_op), .id_alu_src_imm(a_id_alu_src_imm), .id_reg_write(a_id_reg_write),
      .id_mem_read(a_id_mem_read), .id_mem_write(a_id_mem_write), .id_branch(a_id_branch),
      .id_jump(a_id_jump), .id_illegal(a_id_illegal)
   );

   // Return to idle: nothing offered, downstream ready, one cycle to drain
   task automatic idle();
      if_valid = 1'b0; id_ready = 1'b1; wb_en = 1'b0; flush = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1; flush = 1'b0; if_valid = 1'b0; if_instr = '0; if_pc = '0;
      wb_en = 1'b0; wb_rd = '0; wb_data = '0; id_ready = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      vectors++; if (id_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got=%b exp=0", id_valid); end
      vectors++; if (if_ready !== 1'b1) begin miscompares++; $display("FAIL reset_if_ready got=%b exp=1", if_ready); end
      vectors++; if ({id_pc, id_imm, id_rs1_data, id_rs2_data} !== 128'h0) begin miscompares++; $display("FAIL reset_data got=%h %h %h %h exp=0", id_pc, id_imm, id_rs1_data, id_rs2_data); end
      vectors++; if ({id_rs1, id_rs2, id_rd, id_alu_op, id_alu_src_imm, id_reg_write, id_mem_read, id_mem_write, id_branch, id_jump, id_illegal} !== 26'h0) begin miscompares++; $display("FAIL reset_ctrl got=%h exp=0", {id_rs1, id_rs2, id_rd, id_alu_op, id_illegal}); end
      vectors++; if (a_id_valid !== 1'b0) begin miscompares++; $display("FAIL reset_alt_valid got=%b exp=0", a_id_valid); end
   endtask

   task automatic test_addi();
      @(negedge clk);
      if_valid = 1'b1; if_instr = 32'hFFF00293; if_pc = 32'h100; id_ready = 1'b1;
      @(negedge clk);
      if_valid = 1'b0;
      vectors++; if (id_valid !== 1'b1) begin miscompares++; $display("FAIL addi_valid got=%b exp=1", id_valid); end
      vectors++; if (id_imm !== 32'hFFFFFFFF) begin miscompares++; $display("FAIL addi_imm got=%h exp=ffffffff", id_imm); end
      vectors++; if (id_rd !== 5'd5) begin miscompares++; $display("FAIL addi_rd got=%0d exp=5", id_rd); end
      vectors++; if ({id_alu_src_imm, id_reg_write, id_illegal} !== 3'b110) begin miscompares++; $display("FAIL addi_flags got=%b exp=110", {id_alu_src_imm, id_reg_write, id_illegal}); end
      vectors++; if (id_pc !== 32'h100) begin miscompares++; $display("FAIL addi_pc got=%h exp=100", id_pc); end
      @(negedge clk);
      vectors++; if (id_valid !== 1'b0) begin miscompares++; $display("FAIL addi_drain got=%b exp=0", id_valid); end
   endtask

   task automatic test_bypass();
      // ADD x1,x3,x3 captured while x3 is written with 0x1234
      if_valid = 1'b1; if_instr = 32'h003180B3; if_pc = 32'h104;
      wb_en = 1'b1; wb_rd = 5'd3; wb_data = 32'h1234;
      @(negedge clk);
      wb_en = 1'b0;
      vectors++; if ({id_rs1_data, id_rs2_data} !== {32'h1234, 32'h1234}) begin miscompares++; $display("FAIL bypass_on got=%h %h exp=1234 1234", id_rs1_data, id_rs2_data); end
      vectors++; if ({a_id_rs1_data, a_id_rs2_data} !== 64'h0) begin miscompares++; $display("FAIL bypass_off got=%h %h exp=0 0", a_id_rs1_data, a_id_rs2_data); end
      vectors++; if ({id_rs1, id_rs2, id_rd} !== {5'd3, 5'd3, 5'd1}) begin miscompares++; $display("FAIL bypass_idx got=%0d %0d %0d exp=3 3 1", id_rs1, id_rs2, id_rd); end
      // Back-to-back repeat now reads the written register file
      @(negedge clk);
      if_valid = 1'b0;
      vectors++; if ({a_id_rs1_data, a_id_rs2_data} !== {32'h1234, 32'h1234}) begin miscompares++; $display("FAIL regfile_read got=%h %h exp=1234 1234", a_id_rs1_data, a_id_rs2_data); end
      idle();
   endtask

   task automatic test_stall();
      // SW x7,4(x2) held by a stalled execute stage
      if_valid = 1'b1; if_instr = 32'h00712223; if_pc = 32'h200; id_ready = 1'b0;
      @(negedge clk);
      if_instr = 32'hFFF00293;
      wb_en = 1'b1; wb_rd = 5'd7; wb_data = 32'hDEAD;
      vectors++; if (if_ready !== 1'b0) begin miscompares++; $display("FAIL stall_if_ready got=%b exp=0", if_ready); end
      vectors++; if (id_rs2_data !== 32'h0) begin miscompares++; $display("FAIL stall_rs2_before got=%h exp=0", id_rs2_data); end
      @(negedge clk);
      wb_en = 1'b0;
      vectors++; if (id_rs2_data !== 32'hDEAD) begin miscompares++; $display("FAIL stall_hold_upd got=%h exp=dead", id_rs2_data); end
      vectors++; if (a_id_rs2_data !== 32'h0) begin miscompares++; $display("FAIL stall_hold_nobyp got=%h exp=0", a_id_rs2_data); end
      vectors++; if (id_imm !== 32'h4) begin miscompares++; $display("FAIL stall_imm got=%h exp=4", id_imm); end
      vectors++; if ({id_valid, if_ready, id_mem_write, id_rs2, id_rd} !== {3'b101, 5'd7, 5'd0}) begin miscompares++; $display("FAIL stall_ctrl got=%b%b%b rs2=%0d rd=%0d exp=101 7 0", id_valid, if_ready, id_mem_write, id_rs2, id_rd); end
      if_valid = 1'b0; id_ready = 1'b1;
      @(negedge clk);
      vectors++; if (id_valid !== 1'b0) begin miscompares++; $display("FAIL stall_release got=%b exp=0", id_valid); end
   endtask

   task automatic test_jal_and_rv32e();
      if_valid = 1'b1; if_instr = 32'hFF9FF06F; if_pc = 32'h300; id_ready = 1'b1;
      @(negedge clk);
      vectors++; if (id_imm !== 32'hFFFFFFF8) begin miscompares++; $display("FAIL jal_imm got=%h exp=fffffff8", id_imm); end
      vectors++; if ({id_jump, id_reg_write, id_rd} !== {2'b10, 5'd0}) begin miscompares++; $display("FAIL jal_ctrl got=%b%b rd=%0d exp=10 0", id_jump, id_reg_write, id_rd); end
      // ADD x17,x1,x2: legal with 32 registers, illegal with 16
      if_instr = 32'h002088B3;
      @(negedge clk);
      if_valid = 1'b0;
      vectors++; if ({a_id_illegal, a_id_reg_write} !== 2'b10) begin miscompares++; $display("FAIL rv32e_x17 got=%b%b exp=10", a_id_illegal, a_id_reg_write); end
      vectors++; if ({id_illegal, id_reg_write, id_rd} !== {2'b01, 5'd17}) begin miscompares++; $display("FAIL rv32i_x17 got=%b%b rd=%0d exp=01 17", id_illegal, id_reg_write, id_rd); end
      idle();
   endtask

   task automatic test_back_to_back();
      logic [31:0] instr [9];
      logic [31:0] imm   [9];
      logic [3:0]  aop   [9];
      logic [2:0]  flg   [9];   // {illegal, reg_write, branch}
      logic        cimm  [9];
      instr[0] = 32'h4030D093; imm[0] = 32'h403;      aop[0] = 4'hD; flg[0] = 3'b010; cimm[0] = 1; // SRAI x1,x1,3
      instr[1] = 32'h0020C463; imm[1] = 32'h8;        aop[1] = 4'h4; flg[1] = 3'b001; cimm[1] = 1; // BLT x1,x2,+8
      instr[2] = 32'hABCDE537; imm[2] = 32'hABCDE000; aop[2] = 4'h0; flg[2] = 3'b010; cimm[2] = 1; // LUI x10
      instr[3] = 32'h40001033; imm[3] = 32'h0;        aop[3] = 4'h9; flg[3] = 3'b100; cimm[3] = 1; // OP f7=0x20 on SLL
      instr[4] = 32'h0000007F; imm[4] = 32'h0;        aop[4] = 4'h0; flg[4] = 3'b100; cimm[4] = 0; // unknown opcode
      instr[5] = 32'hFFF00290; imm[5] = 32'h0;        aop[5] = 4'h0; flg[5] = 3'b100; cimm[5] = 0; // low bits != 11
      instr[6] = 32'h00000073; imm[6] = 32'h0;        aop[6] = 4'h0; flg[6] = 3'b000; cimm[6] = 0; // ECALL
      instr[7] = 32'h00100073; imm[7] = 32'h0;        aop[7] = 4'h0; flg[7] = 3'b000; cimm[7] = 0; // EBREAK
      instr[8] = 32'h0FF0000F; imm[8] = 32'h0;        aop[8] = 4'h0; flg[8] = 3'b000; cimm[8] = 0; // FENCE
      id_ready = 1'b1;
      for (int i = 0; i <= 9; i++) begin
         if (i > 0) begin
            vectors++; if ({id_valid, id_pc} !== {1'b1, 32'h1000 + 32'(4 * (i - 1))}) begin miscompares++; $display("FAIL b2b_valid_pc[%0d] got=%b %h exp=1 %h", i - 1, id_valid, id_pc, 32'h1000 + 32'(4 * (i - 1))); end
            vectors++; if ({id_illegal, id_reg_write, id_branch} !== flg[i-1]) begin miscompares++; $display("FAIL b2b_flags[%0d] got=%b exp=%b", i - 1, {id_illegal, id_reg_write, id_branch}, flg[i-1]); end
            if (cimm[i-1]) begin
               vectors++; if ({id_imm, id_alu_op} !== {imm[i-1], aop[i-1]}) begin miscompares++; $display("FAIL b2b_imm_op[%0d] got=%h %h exp=%h %h", i - 1, id_imm, id_alu_op, imm[i-1], aop[i-1]); end
            end
            if (i - 1 >= 6) begin
               vectors++; if ({id_mem_read, id_mem_write, id_jump, id_alu_src_imm} !== 4'b0) begin miscompares++; $display("FAIL b2b_nop_en[%0d] got=%b exp=0000", i - 1, {id_mem_read, id_mem_write, id_jump, id_alu_src_imm}); end
            end
         end
         if (i < 9) begin
            if_valid = 1'b1; if_instr = instr[i]; if_pc = 32'h1000 + 32'(4 * i);
         end else begin
            if_valid = 1'b0;
         end
         @(negedge clk);
      end
      idle();
   endtask

   task automatic test_flush();
      if_valid = 1'b1; if_instr = 32'hFFF00293; if_pc = 32'h400; id_ready = 1'b0;
      @(negedge clk);
      vectors++; if (id_valid !== 1'b1) begin miscompares++; $display("FAIL flush_pre got=%b exp=1", id_valid); end
      flush = 1'b1; if_instr = 32'hABCDE537; id_ready = 1'b1;
      wb_en = 1'b1; wb_rd = 5'd5; wb_data = 32'h55;
      @(negedge clk);
      flush = 1'b0; if_valid = 1'b0; wb_en = 1'b0;
      vectors++; if ({id_valid, a_id_valid, if_ready} !== 3'b001) begin miscompares++; $display("FAIL flush_kill got=%b%b%b exp=001", id_valid, a_id_valid, if_ready); end
      vectors++; if (id_imm === 32'hABCDE000) begin miscompares++; $display("FAIL flush_no_capture got=%h exp=not abcde000", id_imm); end
      @(negedge clk);
      vectors++; if (id_valid !== 1'b0) begin miscompares++; $display("FAIL flush_stays got=%b exp=0", id_valid); end
   endtask

   task automatic test_reset_mid();
      // ADDI x6,x5,0 sees the write performed under flush
      if_valid = 1'b1; if_instr = 32'h00028313; if_pc = 32'h500; id_ready = 1'b0;
      @(negedge clk);
      if_valid = 1'b0;
      vectors++; if ({id_rs1_data, a_id_rs1_data} !== {32'h55, 32'h55}) begin miscompares++; $display("FAIL flush_wb got=%h %h exp=55 55", id_rs1_data, a_id_rs1_data); end
      #2 rst = 1'b1;
      #1;
      vectors++; if ({id_valid, a_id_valid} !== 2'b00) begin miscompares++; $display("FAIL async_rst got=%b%b exp=00", id_valid, a_id_valid); end
      @(negedge clk);
      rst = 1'b0; id_ready = 1'b1;
      if_valid = 1'b1; if_instr = 32'h00028313; if_pc = 32'h504;
      @(negedge clk);
      if_valid = 1'b0;
      vectors++; if ({id_valid, id_rs1, id_rs1_data} !== {1'b1, 5'd5, 32'h0}) begin miscompares++; $display("FAIL rst_x5 got=%b %0d %h exp=1 5 0", id_valid, id_rs1, id_rs1_data); end
      idle();
   endtask

   initial begin
      test_reset();
      test_addi();
      test_bypass();
      test_stall();
      test_jal_and_rv32e();
      test_back_to_back();
      test_flush();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
